// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiply and
// restoring divide over WIDTH cycles, with a sign fix-up cycle before results load.
module execute_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             sa_q, sa_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshift;
    logic             dge;
    logic [WIDTH-1:0] dsub;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy  = (state_q == S_CALC) || (state_q == S_FIX);
    assign done  = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        accept    = start && ready && !flush;
        op_signed = !op[0];
        mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

        // Multiply: sh holds the multiplier and the low product bits shift in from the top.
        msum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : '0);

        // Divide: acc is the partial remainder, sh shifts dividend out and quotient in.
        dshift = {acc_q, sh_q[WIDTH-1]};
        dge    = dshift >= {1'b0, dvs_q};
        dsub   = dshift[WIDTH-1:0] - dvs_q;

        prod   = {acc_q, sh_q};
        prod_s = (!op_q[0] && neg_q) ? -prod : prod;
        quo_s  = dz_q ? '1 : ((!op_q[0] && neg_q) ? -sh_q : sh_q);
        rem_s  = (!op_q[0] && sa_q) ? -acc_q : acc_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_CALC: begin
                if (op_q[1]) begin
                    acc_d = dge ? dsub : dshift[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], dge};
                end else begin
                    acc_d = msum[WIDTH:1];
                    sh_d  = {msum[0], sh_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q[1]) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            op_d    = op;
            acc_d   = '0;
            sh_d    = mag_a;
            dvs_d   = mag_b;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            sa_d    = a[WIDTH-1];
            dz_d    = op[1] && (b == '0);
        end

        // Flush aborts in any state; hi/lo only ever change in FIX, which flush pre-empts.
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: arithmetic reference model with cycle-by-cycle output
// comparison, plus directed vectors carrying hand-computed results and latencies.
module tb_execute_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    execute_muldiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint        sx, sy, q, rm;
        longint unsigned ux, uy;
        logic [63:0]   r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            2'b00: r = sx * sy;
            2'b01: r = ux * uy;
            2'b10: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Model: an accepted op completes WIDTH+1 edges after the accept edge unless flushed.
    logic        m_pend  = 1'b0;
    logic        m_done  = 1'b0;
    int          m_age   = 0;
    logic [63:0] m_res   = '0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pend = 1'b0;
            m_done = 1'b0;
            m_age  = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_pend = 1'b0;
            end else if (start && !m_pend) begin
                m_pend = 1'b1;
                m_age  = 0;
                m_res  = model(op, a, b);
            end else if (m_pend) begin
                m_age++;
                if (m_age == W + 1) begin
                    m_pend = 1'b0;
                    m_done = 1'b1;
                    m_hi   = m_res[63:32];
                    m_lo   = m_res[31:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", {63'h0, ready}, {63'h0, !m_pend});
        chk("busy",  {63'h0, busy},  {63'h0, m_pend});
        chk("done",  {63'h0, done},  {63'h0, m_done});
        chk("hi",    {32'h0, hi},    {32'h0, m_hi});
        chk("lo",    {32'h0, lo},    {32'h0, m_lo});
    end

    // Called #1 after a rising edge with the unit ready; returns #1 after the edge that raised done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string nm, input bit poke);
        int n;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            if (poke && n == 3) begin start = 1'b1; op = 2'b01; a = ~x; b = 32'h3; end
            if (poke && n == 5) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd34);
        chk({nm, "_hi"}, {32'h0, hi}, {32'h0, eh});
        chk({nm, "_lo"}, {32'h0, lo}, {32'h0, el});
        $display("op %s: op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", nm, o, x, y, hi, lo, n);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    logic [63:0] r;

    initial begin
        resetn = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #2;
        chk("rst_ready", {63'h0, ready}, 64'd1);
        chk("rst_busy",  {63'h0, busy},  64'd0);
        chk("rst_done",  {63'h0, done},  64'd0);
        chk("rst_hilo",  {hi, lo},       64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(1);

        run_op(2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_m1x2", 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, "multu_b2b", 1'b0);
        idle(2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2", 1'b0);
        idle(1);
        run_op(2'b11, 32'h7, 32'h2, 32'h1, 32'h3, "divu_7_2_poke", 1'b1);
        idle(1);
        run_op(2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, "div_by0", 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_min2", 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5", 1'b0);
        r = model(2'b10, 32'h7, 32'hFFFF_FFFE);
        run_op(2'b10, 32'h7, 32'hFFFF_FFFE, r[63:32], r[31:0], "div_7_m2", 1'b0);
        r = model(2'b11, 32'hDEAD_BEEF, 32'h1234);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h1234, r[63:32], r[31:0], "divu_big", 1'b0);
        idle(2);

        // Simultaneous flush and start in IDLE: start dropped.
        flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'h9; b = 32'h9;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", {63'h0, busy}, 64'd0);
        $display("flush+start together: busy=%0d", busy);
        idle(1);

        // Flush ten cycles into a MULTU; prior result from divu_big must survive.
        start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", {63'h0, ready}, 64'd1);
        chk("flush_done",  {63'h0, done},  64'd0);
        chk("flush_hilo",  {hi, lo},       model(2'b11, 32'hDEAD_BEEF, 32'h1234));
        $display("flush mid-MULTU: ready=%0d hi=%h lo=%h", ready, hi, lo);
        run_op(2'b01, 32'h3, 32'h5, 32'h0, 32'hF, "multu_after_flush", 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_b2b", 1'b0);
        idle(2);

        // Reset mid-DIV.
        start = 1'b1; op = 2'b10; a = 32'hFFFF_FF00; b = 32'h3;
        @(posedge clk); #1;
        start = 1'b0;
        idle(5);
        resetn = 1'b0;
        #1;
        chk("rstmid_ready", {63'h0, ready}, 64'd1);
        chk("rstmid_busy",  {63'h0, busy},  64'd0);
        chk("rstmid_done",  {63'h0, done},  64'd0);
        chk("rstmid_hilo",  {hi, lo},       64'd0);
        $display("reset mid-DIV: ready=%0d busy=%0d hi=%h lo=%h", ready, busy, hi, lo);
        idle(2);
        resetn = 1'b1;
        idle(1);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_reset", 1'b0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
